// File: rtl/morse_symbol_decoder.sv
// Morse key front end: synchronise and debounce the key, classify presses as dot/dash,
// close a letter after a silent gap and hand its ASCII glyph address and slot to the text controller.
module morse_symbol_decoder #(
  parameter int DEBOUNCE_CYCLES   = 250_000,
  parameter int DOT_MAX_CYCLES    = 6_250_000,
  parameter int LETTER_GAP_CYCLES = 12_500_000,
  parameter int MAX_SYMBOLS       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_in,
  output logic [2:0]  display_position,
  output logic [10:0] addr_fixed,
  output logic        char_valid,
  output logic        decode_err
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(DOT_MAX_CYCLES) + 1;
  localparam int GW = $clog2(LETTER_GAP_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] DOT_MAX   = PW'(DOT_MAX_CYCLES);
  localparam logic [PW-1:0] PRESS_SAT = PW'(DOT_MAX_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LIM   = GW'(LETTER_GAP_CYCLES);
  localparam logic [2:0]    LEN_MAX   = 3'(MAX_SYMBOLS);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic                   key_db_q, key_db_d;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic [PW-1:0]          press_cnt_q, press_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [MAX_SYMBOLS-1:0] pattern_q, pattern_d;
  logic [2:0]             len_q, len_d;
  logic                   ovf_q, ovf_d;
  logic [10:0]            addr_q, addr_d;
  logic [2:0]             pos_q, pos_d;
  logic [2:0]             slot_q, slot_d;
  logic                   err_q, err_d;

  logic          sym_done, sym_bit, gap_expire;
  logic [GW-1:0] gap_next;
  logic [4:0]    pat5;
  logic [6:0]    lut_ascii;
  logic          lut_err;

  assign sym_done   = (state_q == PRESS) && !key_db_q;
  assign sym_bit    = (press_cnt_q > DOT_MAX);
  assign gap_next   = gap_cnt_q + 1'b1;
  assign gap_expire = (state_q == GAP) && (gap_next == GAP_LIM);

  always_comb begin
    sync_d   = {sync_q[0], key_in};
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (sync_q[1] != key_db_q) begin
      if (db_cnt_q == DB_LAST) key_db_d = sync_q[1];
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Closing the letter wins over a press that lands on the final gap cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_db_q) state_d = PRESS;
      PRESS:   if (!key_db_q) state_d = GAP;
      GAP:     if (gap_expire) state_d = EMIT;
               else if (key_db_q) state_d = PRESS;
      EMIT:    state_d = key_db_q ? PRESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    addr_d      = addr_q;
    pos_d       = pos_q;
    slot_d      = slot_q;
    err_d       = err_q;
    if ((state_d == PRESS) && (state_q != PRESS)) press_cnt_d = PW'(1);
    else if ((state_q == PRESS) && key_db_q && (press_cnt_q != PRESS_SAT))
      press_cnt_d = press_cnt_q + 1'b1;
    if (sym_done) gap_cnt_d = GW'(1);
    else if (state_q == GAP) gap_cnt_d = gap_next;
    if (gap_expire) begin
      addr_d    = {lut_ascii, 4'b0000};
      err_d     = lut_err;
      pos_d     = slot_q;
      slot_d    = slot_q + 3'd1;
      pattern_d = '0;
      len_d     = '0;
      ovf_d     = 1'b0;
    end else if (sym_done) begin
      if (len_q == LEN_MAX) ovf_d = 1'b1;
      else begin
        pattern_d = {pattern_q[MAX_SYMBOLS-2:0], sym_bit};
        len_d     = len_q + 3'd1;
      end
    end
  end

  // Key is {len, pattern}; the first symbol sits at bit len-1, dash = 1.
  always_comb begin
    pat5      = 5'(pattern_q);
    lut_ascii = 7'h3F;
    lut_err   = 1'b0;
    case ({len_q, pat5})
      8'b001_00000: lut_ascii = 7'h45;
      8'b001_00001: lut_ascii = 7'h54;
      8'b010_00000: lut_ascii = 7'h49;
      8'b010_00001: lut_ascii = 7'h41;
      8'b010_00010: lut_ascii = 7'h4E;
      8'b010_00011: lut_ascii = 7'h4D;
      8'b011_00000: lut_ascii = 7'h53;
      8'b011_00001: lut_ascii = 7'h55;
      8'b011_00010: lut_ascii = 7'h52;
      8'b011_00011: lut_ascii = 7'h57;
      8'b011_00100: lut_ascii = 7'h44;
      8'b011_00101: lut_ascii = 7'h4B;
      8'b011_00110: lut_ascii = 7'h47;
      8'b011_00111: lut_ascii = 7'h4F;
      8'b100_00000: lut_ascii = 7'h48;
      8'b100_00001: lut_ascii = 7'h56;
      8'b100_00010: lut_ascii = 7'h46;
      8'b100_00100: lut_ascii = 7'h4C;
      8'b100_00110: lut_ascii = 7'h50;
      8'b100_00111: lut_ascii = 7'h4A;
      8'b100_01000: lut_ascii = 7'h42;
      8'b100_01001: lut_ascii = 7'h58;
      8'b100_01010: lut_ascii = 7'h43;
      8'b100_01011: lut_ascii = 7'h59;
      8'b100_01100: lut_ascii = 7'h5A;
      8'b100_01101: lut_ascii = 7'h51;
      8'b101_01111: lut_ascii = 7'h31;
      8'b101_00111: lut_ascii = 7'h32;
      8'b101_00011: lut_ascii = 7'h33;
      8'b101_00001: lut_ascii = 7'h34;
      8'b101_00000: lut_ascii = 7'h35;
      8'b101_10000: lut_ascii = 7'h36;
      8'b101_11000: lut_ascii = 7'h37;
      8'b101_11100: lut_ascii = 7'h38;
      8'b101_11110: lut_ascii = 7'h39;
      8'b101_11111: lut_ascii = 7'h30;
      default:      lut_err   = 1'b1;
    endcase
    if (ovf_q) begin
      lut_ascii = 7'h3F;
      lut_err   = 1'b1;
    end
  end

  always_comb begin
    char_valid = (state_q == EMIT);
    decode_err = (state_q == EMIT) && err_q;
  end

  assign addr_fixed       = addr_q;
  assign display_position = pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      key_db_q    <= 1'b0;
      db_cnt_q    <= '0;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      pattern_q   <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      addr_q      <= '0;
      pos_q       <= '0;
      slot_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      key_db_q    <= key_db_d;
      db_cnt_q    <= db_cnt_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      addr_q      <= addr_d;
      pos_q       <= pos_d;
      slot_q      <= slot_d;
      err_q       <= err_d;
    end
  end

endmodule
